atm_pager_ext: RTL and testbench



---
 rtl/atm_pkg.sv | 55 +++++
 rtl/atm_pager_ext_if.sv | 19 +
 rtl/atm_pager_ext_stall.sv | 26 ++
 rtl/atm_pager_ext.sv | 148 ++++++++++++++
 tb/tb_atm_pager_ext.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM/Pent1m memory pager.
//   PG_MAX   widest page number any pager instance can hold
//   DOS_SIG  za[13:8] of an opcode fetch that enters TR-DOS (3Dxx)
//   map_t    one page map: page number, RAM select, 7FFD/DOS mixing, write protect
//   map_rst  reset contents of map m in window addr for a given page width
package atm_pkg;

   localparam int         PG_MAX  = 14;
   localparam logic [5:0] DOS_SIG = 6'h3D;

   // Reset page numbers. Window 0 counts down from the top of the page space.
   localparam int RST_PG0_EVEN_SUB = 1;
   localparam int RST_PG0_ODD_SUB  = 3;
   localparam int RST_PG1          = 5;
   localparam int RST_PG2          = 2;
   localparam int RST_PG3          = 0;

   typedef struct packed {
      logic [PG_MAX-1:0] pg;
      logic              ram;
      logic              d7;
      logic              wp;
   } map_t;

   function automatic map_t map_rst(input logic [1:0] addr, input int m, input int pagew);
      map_t r;
      int   ones;
      ones = (1 << pagew) - 1;
      r    = '0;
      case (addr)
         2'd0: begin
            r.pg  = PG_MAX'((m % 2 == 1) ? ones - RST_PG0_ODD_SUB : ones - RST_PG0_EVEN_SUB);
            r.ram = 1'b0;
            r.d7  = 1'b1;
         end
         2'd1: begin
            r.pg  = PG_MAX'(RST_PG1);
            r.ram = 1'b1;
            r.d7  = 1'b0;
         end
         2'd2: begin
            r.pg  = PG_MAX'(RST_PG2);
            r.ram = 1'b1;
            r.d7  = 1'b0;
         end
         default: begin
            r.pg  = PG_MAX'(RST_PG3);
            r.ram = 1'b1;
            r.d7  = 1'b1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/atm_pager_ext_if.sv
// Z80 bus view seen by a pager instance.
//   zpos/zneg       Z80 clock edge strobes (one fclk wide)
//   za/zd           address and data bus
//   mreq_n/m1_n     memory request and opcode fetch strobes
//   cfg_wr/ext_wr   xxF7 and xx77 port write strobes
// master drives the bus (CPU side), slave is the pager.
interface atm_pager_ext_if;
   logic        zpos;
   logic        zneg;
   logic [15:0] za;
   logic [7:0]  zd;
   logic        mreq_n;
   logic        m1_n;
   logic        cfg_wr;
   logic        ext_wr;

   modport master (output zpos, zneg, za, zd, mreq_n, m1_n, cfg_wr, ext_wr);
   modport slave  (input  zpos, zneg, za, zd, mreq_n, m1_n, cfg_wr, ext_wr);
endinterface

// File: rtl/atm_pager_ext_stall.sv
// dos_stall_ctr: holds the Z80 clock stall after a DOS entry.
//   fclk, rst_n  clock, async active-low reset
//   load         DOS entry strobe; (re)loads STALL_CYC, even mid-count
//   stall        high on the load cycle and while the count is nonzero
module dos_stall_ctr
   import atm_pkg::*;
#(
   parameter int STALL_CYC = 3
) (
   input  logic fclk,
   input  logic rst_n,
   input  logic load,
   output logic stall
);

   logic [3:0] cnt;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)            cnt <= 4'd0;
      else if (load)         cnt <= 4'(STALL_CYC);
      else if (cnt != 4'd0)  cnt <= cnt - 4'd1;
   end

   assign stall = load | (cnt != 4'd0);

endmodule

// File: rtl/atm_pager_ext.sv
// atm_pager_ext: page mapper for one 16 KB CPU window.
//   fclk, rst_n        system clock, async active-low reset
//   bus                Z80 bus (slave modport)
//   pager_off          force service ROM
//   map_sel            active map
//   p7ffd_page/ram0/1m 7FFD paging state
//   dos                current DOS state
//   page, romnram      registered physical page and ROM select
//   wr_protect         registered write block for this window
//   page_rd            registered raw page of the active map
//   dos_turn_on/off    combinational single-fclk DOS strobes
//   zclk_stall         Z80 clock stall after DOS entry
module atm_pager_ext
   import atm_pkg::*;
#(
   parameter logic [1:0] ADDR      = 2'b00,
   parameter int         NMAPS     = 2,
   parameter int         PAGEW     = 8,
   parameter int         DOS_MAP   = 1,
   parameter int         STALL_CYC = 3,
   localparam int        MAPW      = $clog2(NMAPS)
) (
   input  logic             fclk,
   input  logic             rst_n,
   atm_pager_ext_if.slave   bus,
   input  logic             pager_off,
   input  logic [MAPW-1:0]  map_sel,
   input  logic [5:0]       p7ffd_page,
   input  logic             p7ffd_ram0,
   input  logic             p7ffd_1m,
   input  logic             dos,
   output logic [PAGEW-1:0] page,
   output logic             romnram,
   output logic             wr_protect,
   output logic [PAGEW-1:0] page_rd,
   output logic             dos_turn_on,
   output logic             dos_turn_off,
   output logic             zclk_stall
);

   // Extended page bits that exist for this PAGEW (zero when PAGEW == 8).
   localparam logic [5:0] HI_MASK = 6'((1 << (PAGEW - 8)) - 1);

   map_t             maps [NMAPS];
   map_t             cur;
   map_t             wr_map;
   logic             hit;
   logic [PAGEW-1:0] pg_cur;
   logic [PAGEW-1:0] page_nx;
   logic             rom_nx;
   logic             m1_reg;
   logic             mreq_reg;
   logic             fs;
   logic             unused_za;

   assign hit       = (bus.za[15:14] == ADDR);
   assign cur       = maps[map_sel];
   assign pg_cur    = cur.pg[PAGEW-1:0];
   assign unused_za = ^bus.za[7:0];

   // New contents of the selected map. When both strobes land together the
   // low byte comes from cfg_wr and the extended bits from ext_wr.
   always_comb begin
      wr_map = cur;
      if (bus.cfg_wr) begin
         if (bus.za[11]) begin
            wr_map.pg[7:0]        = ~{2'b00, bus.zd[5:0]};
            wr_map.pg[PG_MAX-1:8] = '0;
            wr_map.ram            = bus.zd[6];
            wr_map.d7             = bus.zd[7];
         end else begin
            wr_map.pg[7:0] = ~bus.zd;
            wr_map.ram     = 1'b1;
         end
      end
      if (bus.ext_wr) begin
         wr_map.pg[PG_MAX-1:8] = ~bus.zd[5:0] & HI_MASK;
         wr_map.wp             = bus.zd[7];
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < NMAPS; m++) maps[m] <= map_rst(ADDR, m, PAGEW);
      end else if (hit && (bus.cfg_wr || bus.ext_wr)) begin
         maps[map_sel] <= wr_map;
      end
   end

   // Page selection, highest priority first.
   always_comb begin
      page_nx = pg_cur;
      rom_nx  = ~cur.ram;
      if (pager_off) begin
         page_nx = '1;
         rom_nx  = 1'b1;
      end else if (p7ffd_ram0 && (ADDR == 2'd0)) begin
         page_nx = '0;
         rom_nx  = 1'b0;
      end else if (cur.d7 && cur.ram) begin
         if (p7ffd_1m) page_nx[5:0] = p7ffd_page;
         else          page_nx[2:0] = p7ffd_page[2:0];
      end else if (cur.d7) begin
         // ROM pair: DOS picks between basic and TR-DOS halves
         page_nx[0] = dos;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         page       <= '0;
         romnram    <= 1'b0;
         wr_protect <= 1'b0;
         page_rd    <= '0;
      end else begin
         page       <= page_nx;
         romnram    <= rom_nx;
         wr_protect <= (rom_nx | cur.wp) & ~pager_off;
         page_rd    <= pg_cur;
      end
   end

   // M1 is stable by the rising Z80 edge, MREQ by the falling one; a fetch
   // starts on the zneg where MREQ is newly asserted during M1.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         m1_reg   <= 1'b1;
         mreq_reg <= 1'b1;
      end else begin
         if (bus.zpos) m1_reg   <= bus.m1_n;
         if (bus.zneg) mreq_reg <= bus.mreq_n;
      end
   end

   assign fs = bus.zneg & ~m1_reg & ~bus.mreq_n & mreq_reg & hit;

   assign dos_turn_on  = fs && (bus.za[13:8] == DOS_SIG) && (map_sel == MAPW'(DOS_MAP))
                         && maps[DOS_MAP].d7 && !maps[DOS_MAP].ram;
   assign dos_turn_off = fs & cur.ram;

   dos_stall_ctr #(.STALL_CYC(STALL_CYC)) u_stall (
      .fclk  (fclk),
      .rst_n (rst_n),
      .load  (dos_turn_on),
      .stall (zclk_stall)
   );

endmodule

// File: tb/tb_atm_pager_ext.sv
// Bench for atm_pager_ext: two instances (window 0 / 8-bit pages and
// window 3 / 10-bit pages) on one shared bus, checked every cycle against
// an arithmetic model plus hand-computed directed expectations.
module tb_atm_pager_ext;

   localparam int NK      = 2;
   localparam int DOS_MAP = 1;
   localparam int STALL   = 3;

   logic fclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 fclk = ~fclk;

   atm_pager_ext_if bus ();

   logic [0:0] map_sel    = '0;
   logic       pager_off  = 1'b0;
   logic [5:0] p7ffd_page = '0;
   logic       p7ffd_ram0 = 1'b0;
   logic       p7ffd_1m   = 1'b0;
   logic       dos        = 1'b0;

   logic [7:0] page0, rd0;
   logic [9:0] page3, rd3;
   logic       rom0, wp0, on0, off0, st0;
   logic       rom3, wp3, on3, off3, st3;

   atm_pager_ext #(.ADDR(2'b00), .PAGEW(8)) dut0 (
      .fclk(fclk), .rst_n(rst_n), .bus(bus), .pager_off(pager_off), .map_sel(map_sel),
      .p7ffd_page(p7ffd_page), .p7ffd_ram0(p7ffd_ram0), .p7ffd_1m(p7ffd_1m), .dos(dos),
      .page(page0), .romnram(rom0), .wr_protect(wp0), .page_rd(rd0),
      .dos_turn_on(on0), .dos_turn_off(off0), .zclk_stall(st0));

   atm_pager_ext #(.ADDR(2'b11), .PAGEW(10)) dut3 (
      .fclk(fclk), .rst_n(rst_n), .bus(bus), .pager_off(pager_off), .map_sel(map_sel),
      .p7ffd_page(p7ffd_page), .p7ffd_ram0(p7ffd_ram0), .p7ffd_1m(p7ffd_1m), .dos(dos),
      .page(page3), .romnram(rom3), .wr_protect(wp3), .page_rd(rd3),
      .dos_turn_on(on3), .dos_turn_off(off3), .zclk_stall(st3));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int k_addr [NK] = '{0, 3};
   int k_pw   [NK] = '{8, 10};
   int mpg  [NK][2];
   bit mram [NK][2];
   bit md7  [NK][2];
   bit mwp  [NK][2];
   int e_page [NK];
   int e_rd   [NK];
   bit e_rom  [NK];
   bit e_wp   [NK];
   int last_on [NK];
   bit m1r, mreqr;
   int cyc;

   task automatic model_reset();
      for (int k = 0; k < NK; k++) begin
         for (int m = 0; m < 2; m++) begin
            int ones;
            ones = (1 << k_pw[k]) - 1;
            mwp[k][m] = 1'b0;
            case (k_addr[k])
               0:       begin mpg[k][m] = (m == 0) ? ones - 1 : ones - 3; mram[k][m] = 0; md7[k][m] = 1; end
               1:       begin mpg[k][m] = 5; mram[k][m] = 1; md7[k][m] = 0; end
               2:       begin mpg[k][m] = 2; mram[k][m] = 1; md7[k][m] = 0; end
               default: begin mpg[k][m] = 0; mram[k][m] = 1; md7[k][m] = 1; end
            endcase
         end
         e_page[k] = 0; e_rd[k] = 0; e_rom[k] = 0; e_wp[k] = 0;
         last_on[k] = -1000;
      end
      m1r = 1; mreqr = 1; cyc = 0;
   endtask

   function automatic bit fs_now(input int k);
      return bus.zneg && !m1r && !bus.mreq_n && mreqr && (int'(bus.za[15:14]) == k_addr[k]);
   endfunction

   function automatic bit on_now(input int k);
      return fs_now(k) && (bus.za[13:8] == 6'h3D) && (int'(map_sel) == DOS_MAP)
             && md7[k][DOS_MAP] && !mram[k][DOS_MAP];
   endfunction

   function automatic bit off_now(input int k);
      return fs_now(k) && mram[k][map_sel];
   endfunction

   function automatic bit stall_now(input int k);
      return on_now(k) || ((cyc - last_on[k] >= 1) && (cyc - last_on[k] <= STALL));
   endfunction

   always @(posedge fclk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else begin
         for (int k = 0; k < NK; k++) begin
            int s, pg, ones, hmask, lo, hi;
            s     = int'(map_sel);
            pg    = mpg[k][s];
            ones  = (1 << k_pw[k]) - 1;
            hmask = (1 << (k_pw[k] - 8)) - 1;
            if (on_now(k)) last_on[k] = cyc;
            if (pager_off) begin
               e_page[k] = ones; e_rom[k] = 1;
            end else if (p7ffd_ram0 && k_addr[k] == 0) begin
               e_page[k] = 0; e_rom[k] = 0;
            end else begin
               e_rom[k] = !mram[k][s];
               if (md7[k][s] && mram[k][s])
                  e_page[k] = p7ffd_1m ? pg - pg % 64 + int'(p7ffd_page)
                                       : pg - pg % 8 + int'(p7ffd_page) % 8;
               else if (md7[k][s]) e_page[k] = pg - pg % 2 + int'(dos);
               else                e_page[k] = pg;
            end
            e_wp[k] = (e_rom[k] || mwp[k][s]) && !pager_off;
            e_rd[k] = pg;
            if (int'(bus.za[15:14]) == k_addr[k]) begin
               lo = pg % 256; hi = pg / 256;
               if (bus.cfg_wr && bus.za[11]) begin
                  lo = 255 - int'(bus.zd[5:0]); hi = 0;
                  mram[k][s] = bus.zd[6]; md7[k][s] = bus.zd[7];
               end else if (bus.cfg_wr) begin
                  lo = 255 - int'(bus.zd); mram[k][s] = 1;
               end
               if (bus.ext_wr) begin
                  hi = hmask - (int'(bus.zd) & hmask); mwp[k][s] = bus.zd[7];
               end
               mpg[k][s] = hi * 256 + lo;
            end
         end
         if (bus.zpos) m1r = bus.m1_n;
         if (bus.zneg) mreqr = bus.mreq_n;
         cyc++;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge fclk) begin
      chk("page0",  32'(page0), e_page[0]);
      chk("rom0",   32'(rom0),  32'(e_rom[0]));
      chk("wp0",    32'(wp0),   32'(e_wp[0]));
      chk("rd0",    32'(rd0),   e_rd[0]);
      chk("on0",    32'(on0),   32'(on_now(0)));
      chk("off0",   32'(off0),  32'(off_now(0)));
      chk("stall0", 32'(st0),   32'(stall_now(0)));
      chk("page3",  32'(page3), e_page[1]);
      chk("rom3",   32'(rom3),  32'(e_rom[1]));
      chk("wp3",    32'(wp3),   32'(e_wp[1]));
      chk("rd3",    32'(rd3),   e_rd[1]);
      chk("on3",    32'(on3),   32'(on_now(1)));
      chk("off3",   32'(off3),  32'(off_now(1)));
      chk("stall3", 32'(st3),   32'(stall_now(1)));
   end

   int st_cnt = 0;
   always @(negedge fclk) if (st0) st_cnt++;

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge fclk); #1;
   endtask

   task automatic at_neg();
      @(negedge fclk); #1;
   endtask

   task automatic rearm();
      bus.m1_n = 1; bus.mreq_n = 1; bus.zpos = 1; bus.zneg = 1; tick;
      bus.zpos = 0; bus.zneg = 0;
   endtask

   task automatic fetch(input logic [15:0] a, input bit x_on, input bit x_off, input int x_st);
      st_cnt = 0;
      bus.za = a; bus.m1_n = 0; bus.zpos = 1; tick;
      bus.zpos = 0; bus.zneg = 1; bus.mreq_n = 0;
      at_neg;
      chk("fetch_on0", 32'(on0), 32'(x_on));
      chk("fetch_off3", 32'(off3), 32'(x_off));
      tick; bus.zneg = 0;
      rearm;
      repeat (5) tick;
      at_neg;
      chk("fetch_stall_len", st_cnt, x_st);
   endtask

   initial begin
      model_reset();
      bus.zpos = 0; bus.zneg = 0; bus.za = '0; bus.zd = '0;
      bus.mreq_n = 1; bus.m1_n = 1; bus.cfg_wr = 0; bus.ext_wr = 0;
      repeat (3) tick;
      at_neg;
      chk("rst_page0", 32'(page0), 0);
      chk("rst_rom0",  32'(rom0), 0);
      chk("rst_rd3",   32'(rd3), 0);
      rst_n = 1;

      tick; at_neg;
      chk("map0_page", 32'(page0), 32'hFE);
      chk("map0_rom",  32'(rom0), 1);
      map_sel = 1; tick; at_neg;
      chk("map1_page", 32'(page0), 32'hFC);

      // window 3: F7 write with za[11]=1, then 1 MB 7FFD mixing
      map_sel = 0; bus.cfg_wr = 1; bus.za = 16'hFFF7; bus.zd = 8'hC2; tick;
      bus.cfg_wr = 0; p7ffd_page = 6'h2A; p7ffd_1m = 1; tick; at_neg;
      chk("cfg_page3", 32'(page3), 32'h0EA);
      chk("cfg_rom3",  32'(rom3), 0);
      chk("cfg_rd3",   32'(rd3), 32'h0FD);

      // F7 write with za[11]=0 then 77 extended write
      bus.cfg_wr = 1; bus.za = 16'hF7F7; bus.zd = 8'h00; tick;
      bus.cfg_wr = 0; bus.ext_wr = 1; bus.zd = 8'h81; tick;
      bus.ext_wr = 0; p7ffd_page = 6'h3F; p7ffd_1m = 0; tick; at_neg;
      chk("ext_page3", 32'(page3), 32'h2FF);
      chk("ext_wp3",   32'(wp3), 1);
      chk("ext_rd3",   32'(rd3), 32'h2FF);

      // both strobes in one cycle on map 1
      map_sel = 1; bus.cfg_wr = 1; bus.ext_wr = 1; bus.za = 16'hFFF7; bus.zd = 8'h45; tick;
      bus.cfg_wr = 0; bus.ext_wr = 0; tick; at_neg;
      chk("both_page3", 32'(page3), 32'h2FA);
      chk("both_wp3",   32'(wp3), 0);

      // DOS entry fetches
      fetch(16'h3D2F, 1, 0, STALL + 1);
      map_sel = 0;
      fetch(16'h3D2F, 0, 0, 0);
      fetch(16'hFD00, 0, 1, 0);

      // second entry while the counter is at 2
      map_sel = 1; st_cnt = 0;
      bus.za = 16'h3D00; bus.m1_n = 0; bus.zpos = 1; tick;
      bus.zpos = 0; bus.zneg = 1; bus.mreq_n = 0; tick;
      bus.mreq_n = 1; tick;
      bus.mreq_n = 0; at_neg;
      chk("reload_on0", 32'(on0), 1);
      tick; bus.zneg = 0; bus.mreq_n = 1;
      repeat (6) tick; at_neg;
      chk("reload_stall_len", st_cnt, 6);
      rearm;

      // reset in the middle of a stall
      bus.m1_n = 0; bus.zpos = 1; tick;
      bus.zpos = 0; bus.zneg = 1; bus.mreq_n = 0; tick;
      bus.zneg = 0; bus.mreq_n = 1; tick;
      #2;
      chk("pre_rst_stall", 32'(st0), 1);
      rst_n = 0; #1;
      chk("rst_stall_drop", 32'(st0), 0);
      bus.m1_n = 1; tick; rst_n = 1; tick;

      // pager_off beats the RAM0 shortcut
      pager_off = 1; p7ffd_ram0 = 1; tick; at_neg;
      chk("off_page0", 32'(page0), 32'hFF);
      chk("off_rom0",  32'(rom0), 1);
      chk("off_wp0",   32'(wp0), 0);
      chk("off_page3", 32'(page3), 32'h3FF);
      pager_off = 0; tick; at_neg;
      chk("ram0_page0", 32'(page0), 0);
      chk("ram0_rom0",  32'(rom0), 0);
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
